// File: rtl/fixed_multi_seq.sv
`default_nettype none
// ============================================================================
// Module      : fixed_multi_seq
// Description : Sequential shift-and-add unsigned fixed-point multiplier with
//               optional round-half-up and saturation on the final result.
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_multi_seq #(
    parameter int INT_W    = 8,
    parameter int FRAC_W   = 8,
    parameter int SATURATE = 0,
    parameter int ROUND    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [INT_W+FRAC_W-1:0] num1,
    input  logic [INT_W+FRAC_W-1:0] num2,
    output logic                    busy,
    output logic                    done,
    output logic [INT_W+FRAC_W-1:0] result,
    output logic                    overflow
);

    localparam int c_W     = INT_W + FRAC_W;
    localparam int c_CNT_W = $clog2(c_W + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(c_W);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(1);
    localparam logic [2*c_W:0]     c_ROUND_INC =
        (ROUND != 0) ? ((2*c_W+1)'(1) << (FRAC_W - 1)) : '0;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [2*c_W-1:0]   r_mcand;
    logic [2*c_W-1:0]   r_acc;
    logic [c_W-1:0]     r_mplier;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_W-1:0]     r_result;
    logic               r_overflow;

    logic [2*c_W-1:0]   w_acc_next;
    logic [2*c_W:0]     w_rounded;
    logic               w_ovf;
    logic [c_W-1:0]     w_result;
    logic               w_accept;
    logic               w_last;
    logic               w_unused_frac;

    assign w_accept   = (r_state == c_ST_IDLE) && start;
    assign w_last     = (r_state == c_ST_CALC) && (r_cnt == c_CNT_LAST);
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Final step's partial product is folded in before rounding so the
    // registered result is available on the same edge that leaves CALC.
    assign w_rounded     = {1'b0, w_acc_next} + c_ROUND_INC;
    assign w_ovf         = |w_rounded[2*c_W:FRAC_W+c_W];
    assign w_result      = ((SATURATE != 0) && w_ovf) ? '1
                                                      : w_rounded[FRAC_W+c_W-1:FRAC_W];
    assign w_unused_frac = ^w_rounded[FRAC_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (start)  w_state_next = c_ST_CALC;
            c_ST_CALC: if (w_last) w_state_next = c_ST_DONE;
            c_ST_DONE: w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_ST_CALC: busy = 1'b1;
            c_ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_mcand  <= {{c_W{1'b0}}, num1};
            r_mplier <= num2;
            r_acc    <= '0;
            r_cnt    <= c_CNT_LOAD;
        end else if (r_state == c_ST_CALC) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - c_CNT_LAST;
            if (w_last) begin
                r_result   <= w_result;
                r_overflow <= w_ovf;
            end
        end
    end

    assign result   = r_result;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: doc/fixed_multi_seq.md
FIXED_MULTI_SEQ -- requirements
Module: fixed_multi_seq

Interface
REQ-001 SHALL have parameter INT_W, default 8: integer bits of unsigned fixed-point operands and result.
REQ-002 SHALL have parameter FRAC_W, default 8, minimum 1: fraction bits; W = INT_W+FRAC_W.
REQ-003 SHALL have parameter SATURATE, default 0: 1 = result clamps to all-ones on overflow; 0 = result wraps (truncated).
REQ-004 SHALL have parameter ROUND, default 0: 1 = round-half-up at bit FRAC_W-1 before truncation; 0 = truncate.
REQ-005 SHALL have one clock and an asynchronous, active-low reset (clk, rst_n).
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 start  input  1  request; sampled only in IDLE.
REQ-009 num1  input  W  multiplicand, unsigned IIII.FFFF format.
REQ-010 num2  input  W  multiplier, same format.
REQ-011 busy  output  1  high in CALC and DONE states.
REQ-012 done  output  1  one-cycle pulse; result/overflow valid from this cycle.
REQ-013 result  output  W  product in same fixed format.
REQ-014 overflow  output  1  product integer part exceeds INT_W bits.

Function
REQ-015 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; no other states reachable.
REQ-016 IDLE with start=1 at an edge: SHALL latch num1, num2, clear 2W-bit accumulator, load bit counter with W, enter CALC.
REQ-017 CALC: each cycle SHALL add the shifted multiplicand to the accumulator if current multiplier LSB is 1, then shift multiplicand left 1, multiplier right 1, decrement counter.
REQ-018 CALC SHALL last exactly W cycles (fixed latency, no early exit on zero multiplier).
REQ-019 On the edge leaving CALC: SHALL register R = acc + (ROUND ? 2^(FRAC_W-1) : 0) using 2W+1 bits; overflow = |R[2W:FRAC_W+W]; result = (SATURATE && overflow) ? all-ones : R[FRAC_W+W-1:FRAC_W].
REQ-020 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-021 done SHALL rise W+1 cycles after the edge that accepted start.
REQ-022 result and overflow SHALL hold their values until the next DONE updates them; inputs changing after acceptance SHALL not affect the operation.
REQ-023 start while busy=1 (CALC or DONE) SHALL be ignored; no queuing; next start accepted only in IDLE.
REQ-024 Operand value 0 in either input SHALL give result 0, overflow 0, with full W+1 latency.
REQ-025 Max operands (all-ones both) SHALL give correct overflow=1 (INT_W>=1) and no internal accumulator wrap.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, result=0, overflow=0, accumulator and counter 0, independent of clk.
REQ-027 Reset asserted mid-CALC or in DONE SHALL abort the operation with no done pulse; first start after rst_n release SHALL be accepted normally.

Verification
REQ-028 Defaults, num1=0x0100, num2=0x0100, start 1 cycle -> busy for 17 cycles, done pulse at cycle 17, result=0x0100, overflow=0.
REQ-029 Defaults, num1=0x8000, num2=0x0200 -> result=0x0000, overflow=1; with SATURATE=1 -> result=0xFFFF, overflow=1.
REQ-030 num1=0x0001, num2=0x0080: ROUND=0 -> result=0x0000; ROUND=1 -> result=0x0001; overflow=0 both.
REQ-031 num1=0x0180, num2=0x0280 (1.5*2.5) -> result=0x03C0; second start pulsed at cycles 5 and 17 ignored, single done pulse only; start at cycle 18 (IDLE) accepted.
REQ-032 Assert rst_n=0 at cycle 8 of CALC -> outputs zero asynchronously, no done; after release num1=0x0300, num2=0x0040 -> result=0x00C0 after 17 cycles.
REQ-033 Parametrised run INT_W=4, FRAC_W=4: num1=0x18, num2=0x20 (1.5*2.0) -> result=0x30, overflow=0, done 9 cycles after start.
